// File: rtl/led_seq_pkg.sv
// Shared types and constants for the on-chip-memory LED sequencer.
package led_seq_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        PLAY    = 2'd3
    } state_t;

    // LED bytes unpacked from one pattern word.
    localparam int BYTES_PER_WORD = 16;

    // Depth of the pattern RAM in words.
    localparam int MAX_WORDS = 64;

    // Loop length as latched at start: requests above the RAM depth are clamped.
    function automatic logic [6:0] clamp_len(input logic [6:0] req_len);
        return (req_len > 7'(MAX_WORDS)) ? 7'(MAX_WORDS) : req_len;
    endfunction

endpackage

// File: rtl/onchip_mem_led_sequencer_if.sv
// Avalon-MM port of the pattern RAM as seen from the sequencer (master) and the RAM (slave).
interface onchip_mem_led_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 128
);
    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                clken;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, chipselect, clken, write, byteenable, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, clken, write, byteenable, writedata,
        output readdata
    );
endinterface

// File: rtl/led_seq_tick_gen.sv
// LED byte-rate divider: counts 0..TICK_DIV-1 and flags the last count as a one-cycle tick.
// A synchronous clear holds the counter at zero so every play period starts on a full byte time.
module led_seq_tick_gen #(
    parameter int TICK_DIV = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Free-running divider, restarted by clear or after the last count.
    // NOTE: sequential state is written with non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = !clear && (count == LAST);

endmodule

// File: rtl/onchip_mem_led_sequencer.sv
// Pattern-RAM LED sequencer: reads 128-bit words over Avalon-MM, plays them one byte per tick
// on the LED bus, and prefetches the following word into a shadow buffer so that word
// boundaries show no gap. Loops over words 0..len-1 while enable is high.
module onchip_mem_led_sequencer
    import led_seq_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 128,    // must equal BYTES_PER_WORD * LED_W
    parameter int LED_W    = 8,
    parameter int TICK_DIV = 5000000 // minimum 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [6:0]                 length,
    onchip_mem_led_sequencer_if.master mem,
    output logic [LED_W-1:0]           leds,
    output logic                       busy,
    output logic                       wrap
);
    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    state_t            state;
    state_t            state_nxt;
    logic              start;

    logic [6:0]        len_q;        // latched loop length, 1..MAX_WORDS
    logic [ADDR_W-1:0] addr_q;       // address of the most recently issued read
    logic              cs_q;         // read strobe, high for one cycle per read
    logic              rd_pending;   // readdata carries the word requested last cycle
    logic              shadow_valid; // shadow holds the next word to play
    logic              stalled;      // boundary tick seen before the next word arrived
    logic [IDX_W-1:0]  byte_idx;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] shadow;

    logic              tick;
    logic              tick_clear;
    logic              at_last;
    logic [ADDR_W-1:0] next_addr;
    logic              issue;
    logic              boundary;
    logic              word_avail;
    logic [DATA_W-1:0] next_word;
    logic [IDX_W-1:0]  byte_nxt;

    // Byte-rate divider; only runs while playing so each word starts on a whole byte period.
    assign tick_clear = (state != PLAY) || !enable;

    led_seq_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: dropping enable returns to IDLE from anywhere.
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (length != 7'd0) begin
                        state_nxt = FETCH;
                        start     = 1'b1;
                    end
                end
                FETCH:   state_nxt = CAPTURE;
                CAPTURE: state_nxt = PLAY;
                PLAY:    state_nxt = PLAY;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Prefetch and word-boundary decisions for the PLAY state.
    always_comb begin
        at_last    = (7'(addr_q) == (len_q - 7'd1));
        next_addr  = at_last ? '0 : addr_q + 1'b1;
        // Only one read may be outstanding, and the strobe must drop between reads.
        issue      = (state == PLAY) && !shadow_valid && !cs_q && !rd_pending;
        // A missed boundary (stalled) is retried every cycle until the next word is on hand.
        boundary   = (state == PLAY) && ((tick && (byte_idx == LAST_IDX)) || stalled);
        // Data arriving this very cycle can be played directly without passing the shadow.
        word_avail = shadow_valid || rd_pending;
        next_word  = shadow_valid ? shadow : mem.readdata;
        byte_nxt   = byte_idx + 1'b1;
    end

    // Control registers: read strobe, address, byte position and the registered LED output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q        <= '0;
            addr_q       <= '0;
            cs_q         <= 1'b0;
            rd_pending   <= 1'b0;
            shadow_valid <= 1'b0;
            stalled      <= 1'b0;
            byte_idx     <= '0;
            leds         <= '0;
            wrap         <= 1'b0;
        end else if (!enable) begin
            // Abandon everything, including a read whose data is still due next cycle.
            addr_q       <= '0;
            cs_q         <= 1'b0;
            rd_pending   <= 1'b0;
            shadow_valid <= 1'b0;
            stalled      <= 1'b0;
            byte_idx     <= '0;
            leds         <= '0;
            wrap         <= 1'b0;
        end else begin
            cs_q       <= 1'b0;
            wrap       <= 1'b0;
            rd_pending <= cs_q;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q  <= clamp_len(length);
                        addr_q <= '0;
                        cs_q   <= 1'b1;
                    end
                end
                CAPTURE: begin
                    byte_idx     <= '0;
                    leds         <= mem.readdata[LED_W-1:0];
                    shadow_valid <= 1'b0;
                    stalled      <= 1'b0;
                end
                PLAY: begin
                    if (issue) begin
                        addr_q <= next_addr;
                        cs_q   <= 1'b1;
                        wrap   <= at_last;
                    end
                    if (boundary) begin
                        if (word_avail) begin
                            byte_idx     <= '0;
                            leds         <= next_word[LED_W-1:0];
                            shadow_valid <= 1'b0;
                            stalled      <= 1'b0;
                        end else begin
                            stalled <= 1'b1;
                        end
                    end else begin
                        if (rd_pending) begin
                            shadow_valid <= 1'b1;
                        end
                        if (tick) begin
                            byte_idx <= byte_nxt;
                            leds     <= cur_word[32'(byte_nxt) * LED_W +: LED_W];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Wide word buffers.
    // NOTE: these data buffers carry no reset; their contents only matter once state/shadow_valid mark them valid.
    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            cur_word <= mem.readdata;
        end else if (boundary && word_avail) begin
            cur_word <= next_word;
        end
        if ((state == PLAY) && rd_pending && !boundary) begin
            shadow <= mem.readdata;
        end
    end

    assign busy           = (state != IDLE);
    assign mem.address    = addr_q;
    assign mem.chipselect = cs_q;
    assign mem.clken      = cs_q;
    assign mem.write      = 1'b0;
    assign mem.byteenable = '1;
    assign mem.writedata  = '0;

endmodule

// File: tb/tb_onchip_mem_led_sequencer.sv
// Self-checking bench for onchip_mem_led_sequencer with TICK_DIV=4 and a latency-1 RAM model.
// Expected LED, strobe, address and wrap values come from a playback-timeline model:
// two set-up cycles, then each word occupies 16*TICK_DIV cycles, and the next word is
// requested on the second cycle of each word.
module tb_onchip_mem_led_sequencer;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 128;
    localparam int LED_W    = 8;
    localparam int TICK     = 4;
    localparam int WORD_CYC = 16 * TICK;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [6:0]       length;
    logic [LED_W-1:0] leds;
    logic             busy;
    logic             wrap;

    logic [DATA_W-1:0] ram [64];

    int n_compared   = 0;
    int n_mismatched = 0;
    logic prev_cs    = 1'b0;

    onchip_mem_led_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    onchip_mem_led_sequencer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LED_W    (LED_W),
        .TICK_DIV (TICK)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .length (length),
        .mem    (bus),
        .leds   (leds),
        .busy   (busy),
        .wrap   (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: data valid one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (bus.chipselect) begin
            bus.readdata <= ram[bus.address];
        end else begin
            bus.readdata <= {$urandom, $urandom, $urandom, $urandom};
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus protocol rules hold on every cycle.
    always @(negedge clk) begin
        check("write_zero", {127'd0, bus.write}, 128'd0);
        check("byteenable", {112'd0, bus.byteenable}, {112'd0, 16'hFFFF});
        check("clken_eq_cs", {127'd0, bus.clken}, {127'd0, bus.chipselect});
        check("cs_back_to_back", {127'd0, prev_cs & bus.chipselect}, 128'd0);
        prev_cs = bus.chipselect;
    end

    function automatic void fill_random();
        for (int w = 0; w < 64; w++) ram[w] = {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void fill_counting();
        for (int w = 0; w < 64; w++)
            for (int i = 0; i < 16; i++) ram[w][i*8 +: 8] = 8'((16 * w + i) & 8'hFF);
    endfunction

    // Start from IDLE at a negedge, check every cycle for ncycles, then stop (enable or reset).
    task automatic play_run(input int len_in, input int ncycles, input bit do_reset);
        int L;
        int b;
        int j;
        logic [7:0] exp_led;
        logic exp_cs;
        logic exp_wrap;
        logic [ADDR_W-1:0] exp_addr;
        L = (len_in > 64) ? 64 : len_in;
        check("idle_before_start", {127'd0, busy}, 128'd0);
        length = 7'(len_in);
        enable = 1'b1;
        for (int n = 0; n < ncycles; n++) begin
            @(negedge clk);
            exp_led  = 8'd0;
            exp_cs   = 1'b0;
            exp_wrap = 1'b0;
            exp_addr = '0;
            if (n >= 2) begin
                b = (n - 2) / TICK;
                exp_led = ram[(b / 16) % L][(b % 16) * 8 +: 8];
            end
            if (n == 0) begin
                exp_cs = 1'b1;
            end else if (n >= 3 && ((n - 3) % WORD_CYC) == 0) begin
                j = (n - 3) / WORD_CYC;
                exp_cs   = 1'b1;
                exp_addr = ADDR_W'((j + 1) % L);
                exp_wrap = ((j % L) == L - 1);
            end
            check($sformatf("leds L=%0d n=%0d", L, n), {120'd0, leds}, {120'd0, exp_led});
            check($sformatf("busy n=%0d", n), {127'd0, busy}, 128'd1);
            check($sformatf("cs n=%0d", n), {127'd0, bus.chipselect}, {127'd0, exp_cs});
            check($sformatf("wrap n=%0d", n), {127'd0, wrap}, {127'd0, exp_wrap});
            if (exp_cs)
                check($sformatf("addr n=%0d", n), {122'd0, bus.address}, {122'd0, exp_addr});
            // Length changes while busy must be ignored.
            length = 7'($urandom_range(0, 127));
        end
        if (do_reset) begin
            #2;
            reset  = 1'b1;
            enable = 1'b0;
            #1;
            check("rst_leds", {120'd0, leds}, 128'd0);
            check("rst_busy", {127'd0, busy}, 128'd0);
            check("rst_cs", {127'd0, bus.chipselect}, 128'd0);
            check("rst_wrap", {127'd0, wrap}, 128'd0);
            check("rst_addr", {122'd0, bus.address}, 128'd0);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check("busy_after_rst", {127'd0, busy}, 128'd0);
            check("leds_after_rst", {120'd0, leds}, 128'd0);
        end else begin
            enable = 1'b0;
            @(negedge clk);
            check("stop_busy", {127'd0, busy}, 128'd0);
            check("stop_leds", {120'd0, leds}, 128'd0);
            check("stop_cs", {127'd0, bus.chipselect}, 128'd0);
            check("stop_wrap", {127'd0, wrap}, 128'd0);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        length = 7'd0;
        fill_counting();
        repeat (3) @(negedge clk);
        check("reset_leds", {120'd0, leds}, 128'd0);
        check("reset_busy", {127'd0, busy}, 128'd0);
        check("reset_cs", {127'd0, bus.chipselect}, 128'd0);
        check("reset_addr", {122'd0, bus.address}, 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single word looped: bytes 00..0F then 00 again, wrap every pass.
        play_run(1, 3 * WORD_CYC + 10, 1'b0);

        // Three words, counting bytes 00..2F, continuous across boundaries.
        play_run(3, 4 * 3 * WORD_CYC + 7, 1'b0);

        // Reset asserted in the middle of playback.
        play_run(3, 90, 1'b1);

        // Zero length never starts.
        length = 7'd0;
        enable = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check($sformatf("len0_busy n=%0d", n), {127'd0, busy}, 128'd0);
            check($sformatf("len0_cs n=%0d", n), {127'd0, bus.chipselect}, 128'd0);
        end
        enable = 1'b0;
        @(negedge clk);

        // Oversized length clamps to 64 words: address reaches 63 then wraps to 0.
        fill_random();
        play_run(100, 64 * WORD_CYC + 40, 1'b0);

        // Drop enable during CAPTURE, then during byte 7; each restart begins at word 0 byte 0.
        fill_random();
        play_run(3, 2, 1'b0);
        play_run(3, 32, 1'b0);
        play_run(3, 2 * WORD_CYC + 20, 1'b0);

        // Randomized loops.
        for (int r = 0; r < 6; r++) begin
            fill_random();
            play_run($urandom_range(1, 70), $urandom_range(2, 600), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
